// File: rtl/phy_reg_free_list_pkg.sv
// rtl/phy_reg_free_list_pkg.sv - shared id width, default sizes and physical-id type for the free list
package phy_reg_free_list_pkg;

  localparam int NUM_PHY_REGS_DEF  = 128;
  localparam int NUM_ARCH_REGS_DEF = 32;

  // msb of a physical id is its valid bit, the rest is the register number
  localparam int PHY_ID_W = $clog2(NUM_PHY_REGS_DEF) + 1;

  typedef logic [PHY_ID_W-1:0] phy_id_t;

  // width needed to count 0..width set lanes
  function automatic int lane_off_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/phy_reg_free_list_lane_compact.sv
// rtl/phy_reg_free_list_lane_compact.sv - prefix popcount turning a lane mask into compacted slot offsets
module lane_compact #(
  parameter int WIDTH = 2,
  parameter int OFF_W = 2
) (
  input  logic [WIDTH-1:0]            mask,
  output logic [WIDTH-1:0][OFF_W-1:0] offset,
  output logic [OFF_W-1:0]            total
);

  logic [OFF_W-1:0] run;

  // each lane's offset is the number of set lanes below it
  always_comb begin
    run    = '0;
    offset = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = run;
      run       = run + OFF_W'(mask[i]);
    end
    total = run;
  end

endmodule

// File: rtl/phy_reg_free_list.sv
// rtl/phy_reg_free_list.sv - circular free list of physical register ids; optional checkpoint under FREELIST_CKPT_EN
module phy_reg_free_list
  import phy_reg_free_list_pkg::*;
#(
  parameter int NUM_PHY_REGS  = NUM_PHY_REGS_DEF,
  parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEF,
  parameter int ALLOC_WIDTH   = 2,
  parameter int FREE_WIDTH    = 2,
  localparam int DEPTH = NUM_PHY_REGS - NUM_ARCH_REGS,
  localparam int ID_W  = $clog2(NUM_PHY_REGS) + 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [ALLOC_WIDTH-1:0]            alloc_req,
  output logic                              alloc_ready,
  output logic [ALLOC_WIDTH-1:0][ID_W-1:0]  alloc_id,
  input  logic [FREE_WIDTH-1:0]             free_valid,
  input  logic [FREE_WIDTH-1:0][ID_W-1:0]   free_id,
`ifdef FREELIST_CKPT_EN
  input  logic                              ckpt_save,
  input  logic                              ckpt_restore,
`endif
  output logic [CNT_W-1:0]                  free_count,
  output logic                              err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int AOFF_W = lane_off_w(ALLOC_WIDTH);
  localparam int FOFF_W = lane_off_w(FREE_WIDTH);
  localparam logic [ID_W-1:0] VALID_BIT = ID_W'(1) << (ID_W - 1);

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] base;
  logic             restore;

  logic [ALLOC_WIDTH-1:0]             grant;
  logic [ALLOC_WIDTH-1:0][AOFF_W-1:0] aoff;
  logic [AOFF_W-1:0]                  atotal;
  logic [ALLOC_WIDTH-1:0][PTR_W-1:0]  a_ptr;

  logic [FREE_WIDTH-1:0]              accept, drop;
  logic [FREE_WIDTH-1:0][FOFF_W-1:0]  foff;
  logic [FOFF_W-1:0]                  ftotal;
  logic [FREE_WIDTH-1:0][PTR_W-1:0]   f_ptr;
  logic [CNT_W:0]                     fill;

  // pointer advance with wrap at DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  assign free_count  = count;
  assign alloc_ready = (count >= CNT_W'(ALLOC_WIDTH));

`ifdef FREELIST_CKPT_EN
  // laps disambiguate head==tail between full and empty when rebuilding the count
  logic [PTR_W-1:0] saved_head;
  logic             saved_lap, head_lap, tail_lap;
  logic [CNT_W-1:0] dist;
  logic             head_wrap, tail_wrap;

  assign restore   = ckpt_restore;
  assign head_wrap = (int'(head) + int'(atotal)) >= DEPTH;
  assign tail_wrap = (int'(tail) + int'(ftotal)) >= DEPTH;

  // free entries between the checkpointed head and the current tail
  always_comb begin
    if (saved_lap == tail_lap) dist = CNT_W'(int'(tail) - int'(saved_head));
    else                       dist = CNT_W'(int'(tail) + DEPTH - int'(saved_head));
  end

  // count before releases: restored distance, or current count less this cycle's grants
  always_comb begin
    base = restore ? dist : (count - CNT_W'(atotal));
  end

  // checkpoint register and lap tracking; restore wins over save
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saved_head <= '0;
      saved_lap  <= 1'b0;
      head_lap   <= 1'b0;
      tail_lap   <= 1'b1;
    end else begin
      if (ckpt_save && !ckpt_restore) begin
        saved_head <= head;
        saved_lap  <= head_lap;
      end
      head_lap <= restore ? saved_lap : (head_lap ^ head_wrap);
      tail_lap <= tail_lap ^ tail_wrap;
    end
  end
`else
  assign restore = 1'b0;

  // count before releases: current count less this cycle's grants
  always_comb begin
    base = count - CNT_W'(atotal);
  end
`endif

  // all-or-nothing grant, blocked during reset and on a checkpoint restore
  always_comb begin
    grant = (alloc_ready && rst_n && !restore) ? alloc_req : '0;
  end

  lane_compact #(.WIDTH(ALLOC_WIDTH), .OFF_W(AOFF_W)) u_alloc_compact (
    .mask   (grant),
    .offset (aoff),
    .total  (atotal)
  );

  // granted lanes read consecutive head-side entries; ungranted lanes show zero
  always_comb begin
    a_ptr    = '0;
    alloc_id = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      a_ptr[i] = ptr_add(head, int'(aoff[i]));
      if (grant[i]) alloc_id[i] = mem[a_ptr[i]];
    end
  end

  // accept valid-tagged releases while the resulting count stays within DEPTH
  always_comb begin
    accept = '0;
    drop   = '0;
    fill   = {1'b0, base};
    for (int i = 0; i < FREE_WIDTH; i++) begin
      if (free_valid[i]) begin
        if (free_id[i][ID_W-1] && (fill < (CNT_W+1)'(DEPTH))) begin
          accept[i] = 1'b1;
          fill      = fill + 1'b1;
        end else begin
          drop[i] = 1'b1;
        end
      end
    end
  end

  lane_compact #(.WIDTH(FREE_WIDTH), .OFF_W(FOFF_W)) u_free_compact (
    .mask   (accept),
    .offset (foff),
    .total  (ftotal)
  );

  // tail-side write slots for accepted releases
  always_comb begin
    f_ptr = '0;
    for (int i = 0; i < FREE_WIDTH; i++) begin
      f_ptr[i] = ptr_add(tail, int'(foff[i]));
    end
  end

  // storage, pointers, count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= VALID_BIT | ID_W'(NUM_ARCH_REGS + i);
      end
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(DEPTH);
      err   <= 1'b0;
    end else begin
      for (int i = 0; i < FREE_WIDTH; i++) begin
        if (accept[i]) mem[f_ptr[i]] <= free_id[i];
      end
`ifdef FREELIST_CKPT_EN
      head <= restore ? saved_head : ptr_add(head, int'(atotal));
`else
      head <= ptr_add(head, int'(atotal));
`endif
      tail  <= ptr_add(tail, int'(ftotal));
      count <= base + CNT_W'(ftotal);
      if (|drop) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phy_reg_free_list.sv
// tb/tb_phy_reg_free_list.sv - directed self-checking bench for phy_reg_free_list
module tb_phy_reg_free_list;
  import phy_reg_free_list_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            alloc_req;
  logic                  alloc_ready;
  logic [1:0][7:0]       alloc_id;
  logic [1:0]            free_valid;
  logic [1:0][7:0]       free_id;
  logic [7:0]            free_count;
  logic                  err;
`ifdef FREELIST_CKPT_EN
  logic                  ckpt_save;
  logic                  ckpt_restore;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  phy_id_t fid;

  phy_reg_free_list dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_req   (alloc_req),
    .alloc_ready (alloc_ready),
    .alloc_id    (alloc_id),
    .free_valid  (free_valid),
    .free_id     (free_id),
`ifdef FREELIST_CKPT_EN
    .ckpt_save   (ckpt_save),
    .ckpt_restore(ckpt_restore),
`endif
    .free_count  (free_count),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_req  = 2'b00;
    free_valid = 2'b00;
    free_id    = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
`ifdef FREELIST_CKPT_EN
    ckpt_save    = 1'b0;
    ckpt_restore = 1'b0;
`endif
    tick();
    alloc_req = 2'b11;
    #1;
    chk("reset_alloc_id_zero", alloc_id, 16'h0000);
    chk("reset_count", free_count, 96);
    chk("reset_err", err, 0);
    chk("reset_ready", alloc_ready, 1);
    do_reset();

    // two-lane alloc straight out of reset
    alloc_req = 2'b11;
    #1;
    chk("alloc11_ids", alloc_id, 16'hA1A0);
    tick();
    idle();
    chk("alloc11_count", free_count, 94);

    // release with valid bit clear is dropped and flags err
    free_valid = 2'b01;
    fid = 8'h05;
    free_id[0] = fid;
    tick();
    idle();
    chk("bad_id_err", err, 1);
    chk("bad_id_count", free_count, 94);
    tick();
    chk("err_sticky", err, 1);

    // asynchronous reset mid-operation
    alloc_req  = 2'b11;
    free_valid = 2'b11;
    free_id    = {8'hB1, 8'hB0};
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_alloc_id", alloc_id, 16'h0000);
    chk("midrst_count", free_count, 96);
    chk("midrst_err", err, 0);
    idle();
    tick();
    rst_n = 1'b1;
    #1;

    // overflow release at full count
    free_valid = 2'b01;
    free_id[0] = 8'h85;
    tick();
    idle();
    chk("ovf_err", err, 1);
    chk("ovf_count", free_count, 96);
    do_reset();
    chk("err_cleared", err, 0);

    // compaction: lane1 alone takes the head entry
    alloc_req = 2'b10;
    #1;
    chk("alloc10_ids", alloc_id, 16'hA000);
    tick();
    chk("alloc10_count", free_count, 95);
    alloc_req = 2'b01;
    #1;
    chk("alloc01_ids", alloc_id, 16'h00A1);
    tick();
    chk("alloc01_count", free_count, 94);

    // drain to one entry
    alloc_req = 2'b11;
    for (int i = 0; i < 46; i++) tick();
    chk("drain_count2", free_count, 2);
    alloc_req = 2'b01;
    #1;
    chk("drain_last_id", alloc_id, 16'h00FE);
    tick();
    chk("drain_count1", free_count, 1);
    #1;
    chk("low_ready", alloc_ready, 0);
    chk("low_no_grant", alloc_id, 16'h0000);
    tick();
    chk("low_count_hold", free_count, 1);

    // refill to ten with ids C0..C8 written at entries 0..8
    alloc_req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      free_valid = 2'b11;
      free_id    = {8'(8'hC1 + 2*k), 8'(8'hC0 + 2*k)};
      tick();
    end
    free_valid = 2'b10;
    free_id    = {8'hC8, 8'h00};
    tick();
    idle();
    chk("refill_count", free_count, 10);
    chk("refill_err", err, 0);

    // same-cycle alloc 2 / free 2: grants wrap 95 -> 0, freed ids not bypassed
    alloc_req  = 2'b11;
    free_valid = 2'b11;
    free_id    = {8'hCA, 8'hC9};
    #1;
    chk("mix_ids", alloc_id, 16'hC0FF);
    tick();
    free_valid = 2'b00;
    chk("mix_count", free_count, 10);
    #1;
    chk("after_wrap_ids", alloc_id, 16'hC2C1);
    tick();
    idle();
    chk("after_wrap_count", free_count, 8);
    chk("final_err", err, 0);

`ifdef FREELIST_CKPT_EN
    do_reset();
    ckpt_save = 1'b1;
    tick();
    ckpt_save = 1'b0;
    alloc_req = 2'b11;
    tick();
    tick();
    alloc_req = 2'b00;
    chk("ckpt_count_before", free_count, 92);
    ckpt_restore = 1'b1;
    tick();
    ckpt_restore = 1'b0;
    chk("ckpt_count_restored", free_count, 96);
    alloc_req = 2'b11;
    #1;
    chk("ckpt_ids", alloc_id, 16'hA1A0);
    tick();
    idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
